bht_predictor: RTL
==================

// Module: bht_predictor
// PURPOSE
//   Parametrised branch-history-table predictor: 2**IDX_W saturating counters of
//   CNT_W bits, indexed by PC XOR global history (gshare; bimodal when HIST_W=0).
//   Sits beside the fetch stage: answers a prediction request one cycle later and
//   trains on resolved branches from execute. Generalises the single 2-bit counter.
// PARAMETERS
//   PC_W    32  width of program-counter inputs
//   IDX_W   4   table index bits; table depth = 2**IDX_W entries
//   CNT_W   2   saturating counter width (>=1)
//   HIST_W  2   global history bits (0..IDX_W); 0 = pure bimodal
// PORTS
//   clk          in   1      clock, all state updates on rising edge
//   rst_n        in   1      synchronous reset, active low
//   req_valid    in   1      prediction request this cycle
//   req_pc       in   PC_W   PC of branch being fetched
//   pred_valid   out  1      prediction available (1 cycle after req_valid)
//   pred_taken   out  1      predicted direction
//   pred_idx     out  IDX_W  table index used; execute returns it unchanged
//   upd_valid    in   1      resolved branch training event
//   upd_idx      in   IDX_W  index captured from pred_idx at prediction time
//   upd_taken    in   1      actual branch outcome
//   upd_mispred  in   1      actual outcome differed from prediction
//   mispred_cnt  out  16     running count of upd_valid&upd_mispred, saturates
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): every counter = 2**(CNT_W-1)-1 (weak not-taken),
//     GHR=0, pred_valid=0, pred_taken=0, pred_idx=0, mispred_cnt=0. Reset wins
//     over any concurrent req/upd; in-flight predictions are discarded.
//   Index: idx = req_pc[IDX_W+1:2] ^ {{(IDX_W-HIST_W){1'b0}}, GHR}; PC bits [1:0] ignored.
//   Predict: latency 1. Cycle N req_valid=1 -> cycle N+1 pred_valid=1,
//     pred_taken = MSB of table[idx] sampled at N, pred_idx = idx. No req -> pred_valid=0,
//     pred_taken/pred_idx hold last value. Back-to-back requests every cycle supported.
//   Update (upd_valid=1): table[upd_idx] += 1 if upd_taken else -= 1, saturating
//     at 2**CNT_W-1 and 0 (no wrap). GHR <= {GHR[HIST_W-2:0], upd_taken}
//     (GHR unused when HIST_W=0). History is non-speculative: updates only here.
//   Same-cycle req and upd, same entry: read-before-write; prediction uses old
//     counter and old GHR; new value visible to requests from next cycle.
//   upd_mispred only feeds mispred_cnt; it does not alter counter update.
//   mispred_cnt: +1 per upd_valid&upd_mispred, holds at 16'hFFFF.
//   CNT_W=1: counter is last-outcome bit; weak not-taken reset value = 0.
//   No X propagation: outputs defined from first reset onward.
// TESTING  (defaults IDX_W=4, CNT_W=2, HIST_W=2)
//   reset, req pc=0x40 -> next cycle pred_valid=1, pred_taken=0, pred_idx=0
//   upd idx=0 taken x1 -> counter 2; req pc=0x40 (GHR=01, idx=1) -> taken=0; idx 0 taken=1 after GHR cleared by 2 not-taken upds
//   upd idx=5 taken x5 -> counter saturates 3; then not-taken x1 -> 2, still taken; x2 more -> 0, not-taken
//   req and upd same idx same cycle, counter 1, upd taken -> pred_taken=0; next req -> 1
//   3 upd with upd_mispred=1, 1 with 0 -> mispred_cnt=3; rst_n low mid-stream -> all regs at reset values next cycle
//   HIST_W=0 build: idx = pc[5:2] regardless of upd history; CNT_W=3 build: saturates at 7

Source files
------------

// File: rtl/bht_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : bht_predictor
//  Purpose  : Gshare / bimodal branch-history-table predictor. A table of
//             2**IDX_W saturating counters, indexed by PC XOR global history,
//             answers fetch-stage requests one cycle later and trains on
//             branches resolved in execute.
//  Revision : 1.0 - initial release
// ============================================================================
module bht_predictor #(
   parameter int PC_W   = 32,
   parameter int IDX_W  = 4,
   parameter int CNT_W  = 2,
   parameter int HIST_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [PC_W-1:0]   req_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [IDX_W-1:0]  pred_idx,
   input  logic              upd_valid,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_taken,
   input  logic              upd_mispred,
   output logic [15:0]       mispred_cnt
);

   localparam int             DEPTH   = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Counter storage and history-derived index mask
   logic [CNT_W-1:0] cnt_tbl [DEPTH];
   logic [IDX_W-1:0] hist_ext;
   logic [IDX_W-1:0] req_idx;
   logic [CNT_W-1:0] upd_cur;
   logic [CNT_W-1:0] upd_next;

   // PC bits outside the index field never influence the prediction
   logic unused_pc_bits;
   assign unused_pc_bits = ^{req_pc[PC_W-1:IDX_W+2], req_pc[1:0]};

   // Global history register exists only for gshare builds
   generate
      if (HIST_W > 0) begin : g_hist
         logic [HIST_W-1:0] ghr;

         // Non-speculative history: shift in resolved outcomes only
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               ghr <= '0;
            end else if (upd_valid) begin
               ghr <= (ghr << 1) | HIST_W'(upd_taken);
            end
         end

         assign hist_ext = IDX_W'(ghr);
      end else begin : g_no_hist
         assign hist_ext = '0;
      end
   endgenerate

   assign req_idx = req_pc[IDX_W+1:2] ^ hist_ext;

   // Saturating increment / decrement of the trained entry
   always_comb begin
      upd_cur  = cnt_tbl[upd_idx];
      upd_next = upd_cur;
      if (upd_taken) begin
         if (upd_cur != CNT_MAX) upd_next = upd_cur + CNT_W'(1);
      end else begin
         if (upd_cur != '0) upd_next = upd_cur - CNT_W'(1);
      end
   end

   // Counter table: reset to weak not-taken, write trained entry on update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            cnt_tbl[i] <= CNT_RST;
         end
      end else if (upd_valid) begin
         cnt_tbl[upd_idx] <= upd_next;
      end
   end

   // Prediction register: table read sees pre-update contents (read-before-write)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_idx   <= '0;
      end else begin
         pred_valid <= req_valid;
         if (req_valid) begin
            pred_taken <= cnt_tbl[req_idx][CNT_W-1];
            pred_idx   <= req_idx;
         end
      end
   end

   // Saturating misprediction counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mispred_cnt <= '0;
      end else if (upd_valid && upd_mispred && (mispred_cnt != 16'hFFFF)) begin
         mispred_cnt <= mispred_cnt + 16'd1;
      end
   end

endmodule
`default_nettype wire
